// File: rtl/vga_pixel_sink.sv
// vga_pixel_sink: 160x120 3-bit framebuffer with a write port driven by plot
// strobes and a free-running VGA-style scan-out on the read port.
// Optional build macro PIXEL_SINK_CLEAR_EN adds a post-reset sweep that zeroes
// the whole framebuffer; without it the framebuffer survives reset.
module vga_pixel_sink #(
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              plot,
  input  logic [7:0]        x,
  input  logic [6:0]        y,
  input  logic [DATA_W-1:0] color,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_color,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start,
  output logic [7:0]        drop_count,
  output logic              clear_busy
);

  // Scan geometry: 200 clocks per line, 125 lines per frame.
  localparam logic [7:0] H_ACTIVE = 8'd160;
  localparam logic [7:0] H_LAST   = 8'd199;
  localparam logic [7:0] HS_FIRST = 8'd168;
  localparam logic [7:0] HS_LAST  = 8'd183;
  localparam logic [6:0] V_ACTIVE = 7'd120;
  localparam logic [6:0] V_LAST   = 7'd124;
  localparam logic [6:0] VS_FIRST = 7'd121;
  localparam logic [6:0] VS_LAST  = 7'd122;
  localparam int         FB_DEPTH = 19200;

  // Linear framebuffer address row*160 + col, built from shifts and adds.
  function automatic logic [14:0] fb_addr(input logic [6:0] row, input logic [7:0] col);
    logic [14:0] r;
    logic [14:0] c;
    r = {8'd0, row};
    c = {7'd0, col};
    return (r << 7) + (r << 5) + c;
  endfunction

  // Saturating increment for the drop counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0]        h_cnt;
  logic [6:0]        v_cnt;
  logic              h_wrap;

  logic              active_p0;
  logic              hs_p0;
  logic              vs_p0;
  logic              fs_p0;
  logic [14:0]       rd_addr_p0;

  logic              vld_p1;
  logic              hsync_p1;
  logic              vsync_p1;
  logic              fs_p1;
  logic [DATA_W-1:0] rd_data_p1;

  logic              in_range;
  logic [14:0]       plot_addr;
  logic              wr_en;
  logic [14:0]       wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              drop_inc;

  logic [DATA_W-1:0] fb_mem [0:FB_DEPTH-1];

  assign h_wrap = (h_cnt == H_LAST);

  // Horizontal and vertical scan counters; reset restarts the frame at (0,0).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? 8'd0 : h_cnt + 8'd1;
      if (h_wrap) begin
        v_cnt <= (v_cnt == V_LAST) ? 7'd0 : v_cnt + 7'd1;
      end
    end
  end

  // ---- stage p0: decode of the current counter position ----
  always_comb begin
    active_p0  = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
    hs_p0      = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    vs_p0      = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    fs_p0      = (h_cnt == 8'd0) && (v_cnt == 7'd0);
    // Blanking positions read address 0 so the read never leaves the array.
    rd_addr_p0 = active_p0 ? fb_addr(v_cnt, h_cnt) : 15'd0;
  end

`ifdef PIXEL_SINK_CLEAR_EN
  localparam logic [14:0] FB_LAST = 15'(FB_DEPTH - 1);

  logic [14:0] clr_addr;
  logic        clr_active;

  // Clear sweep: one address per cycle from 0 to the last entry after every reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_active <= 1'b1;
      clr_addr   <= '0;
    end else if (clr_active) begin
      if (clr_addr == FB_LAST) begin
        clr_active <= 1'b0;
      end
      clr_addr <= clr_addr + 15'd1;
    end
  end

  assign clear_busy = clr_active;
`else
  assign clear_busy = 1'b0;
`endif

  assign in_range  = (x < H_ACTIVE) && (y < V_ACTIVE);
  assign plot_addr = fb_addr(y, x);

  // Write-port arbitration: the clear sweep owns the port and swallows plots.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = plot_addr;
    wr_data  = color;
    drop_inc = 1'b0;
    if (plot) begin
      if (in_range) begin
        wr_en = 1'b1;
      end else begin
        drop_inc = 1'b1;
      end
    end
`ifdef PIXEL_SINK_CLEAR_EN
    if (clr_active) begin
      wr_en    = 1'b1;
      wr_addr  = clr_addr;
      wr_data  = '0;
      drop_inc = 1'b0;
    end
`endif
  end

  // Framebuffer write port; contents are not touched by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fb_mem[wr_addr] <= wr_data;
    end
  end

  // ---- stage p1: registered scan outputs, aligned with the RAM read ----
  // Read-first port: a same-address write this cycle is seen next frame.
  always_ff @(posedge clk) begin
    rd_data_p1 <= fb_mem[rd_addr_p0];
  end

  // Scan control registers, one cycle behind the counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1   <= 1'b0;
      hsync_p1 <= 1'b1;
      vsync_p1 <= 1'b1;
      fs_p1    <= 1'b0;
    end else begin
      vld_p1   <= active_p0 && !clear_busy;
      hsync_p1 <= hs_p0;
      vsync_p1 <= vs_p0;
      fs_p1    <= fs_p0;
    end
  end

  // Saturating count of rejected out-of-range writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (drop_inc) begin
      drop_count <= sat_inc(drop_count);
    end
  end

  assign pix_valid   = vld_p1;
  assign pix_color   = vld_p1 ? rd_data_p1 : '0;
  assign hsync       = hsync_p1;
  assign vsync       = vsync_p1;
  assign frame_start = fs_p1;

endmodule

// File: doc/vga_pixel_sink.md
VGA_PIXEL_SINK -- requirements
Module: vga_pixel_sink

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input, reset_n input.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 plot  input  1  pixel-write strobe; one write per cycle while high.
REQ-005 x  input  8  write column; valid range 0..159.
REQ-006 y  input  7  write row; valid range 0..119.
REQ-007 color  input  3  write colour, {R,G,B}.
REQ-008 pix_valid  output  1  high while pix_color carries an active-area pixel.
REQ-009 pix_color  output  3  scanned-out pixel colour; 3'b000 when pix_valid is low.
REQ-010 hsync  output  1  horizontal sync, active low.
REQ-011 vsync  output  1  vertical sync, active low.
REQ-012 frame_start  output  1  one-cycle pulse coincident with pixel (0,0) on the outputs.
REQ-013 drop_count  output  8  saturating count of rejected writes.
REQ-014 clear_busy  output  1  high while the framebuffer clear sweep runs; constant 0 when PIXEL_SINK_CLEAR_EN is undefined.

Function
REQ-015 Storage SHALL be a 19200 x 3-bit framebuffer with one write port and one read port; address = y*160 + x, 15 bits, computed with shifts and adds: (y<<7) + (y<<5) + x.
REQ-016 A cycle with plot=1, x<160 and y<120 (and clear_busy=0) SHALL write color at that address on the same rising edge.
REQ-017 A cycle with plot=1 and x>=160 or y>=120 SHALL perform no write and SHALL increment drop_count, which saturates at 255.
REQ-018 A write and a scan read to the same address in the same cycle SHALL return the old data; the new data appears on the next frame.
REQ-019 Scan counters: h_cnt 0..199, wrapping to 0; v_cnt 0..124, advancing when h_cnt wraps from 199 and wrapping to 0 after 124; one frame = 25000 cycles.
REQ-020 The active area SHALL be h_cnt<160 and v_cnt<120; hsync SHALL be low for h_cnt 168..183, and vsync SHALL be low for v_cnt 121..122.
REQ-021 All scan outputs SHALL be registered with a latency of 1 cycle from the counters, so that the RAM read data, pix_valid, hsync, vsync and frame_start are mutually aligned.
REQ-022 frame_start SHALL be high exactly one cycle per frame, one cycle after the counters hold (h_cnt=0, v_cnt=0).
REQ-023 Scanning SHALL run continuously and independently of plot; writes never stall the scan and the scan never stalls writes.

Reset
REQ-024 While reset_n=0 the block SHALL hold h_cnt=0, v_cnt=0, pix_valid=0, pix_color=0, hsync=1, vsync=1, frame_start=0 and drop_count=0.
REQ-025 Reset SHALL not clear framebuffer contents unless PIXEL_SINK_CLEAR_EN is defined.
REQ-026 The first frame_start SHALL occur 1 cycle after reset_n rises, because the counters start at (0,0).
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, and scanning SHALL restart at (0,0) on release.

Configuration
REQ-028 With PIXEL_SINK_CLEAR_EN defined, the block SHALL, after reset release, sweep addresses 0..19199 writing 3'b000 at one address per cycle, holding clear_busy=1 for exactly 19200 cycles.
REQ-029 During the clear sweep, plot writes SHALL be ignored and not counted in drop_count, and pix_valid SHALL be forced to 0 while sync timing runs normally.
REQ-030 A reset during the clear sweep SHALL restart the sweep from address 0 on release.
REQ-031 With PIXEL_SINK_CLEAR_EN undefined, no clear logic SHALL exist and clear_busy SHALL be tied to 0.

Verification
REQ-032 Write and read back: plot (x=5, y=3, color=3'b101), then run a frame -> pix_color=3'b101 with pix_valid=1 exactly at scan position (5,3), 1 cycle after the counters reach it.
REQ-033 Out-of-range writes: plot x=160 y=0, then x=0 y=120 -> no RAM change and drop_count=2; apply 300 bad writes -> drop_count holds at 255.
REQ-034 Sync timing: over one frame -> 25000 cycles between frame_start pulses, hsync low 16 cycles per line, vsync low 400 cycles, and pix_valid high for 19200 cycles.
REQ-035 Collision: write new color at address 320 (x=0, y=2) on the cycle that address is scanned -> old value appears this frame and the new value appears next frame.
REQ-036 Reset mid-frame: assert reset_n=0 at v_cnt=60 -> outputs take their reset values at once; after release, frame_start occurs 1 cycle later and earlier writes are retained (macro undefined).
REQ-037 With PIXEL_SINK_CLEAR_EN defined: after reset, clear_busy is high for 19200 cycles, plots during the sweep are ignored, and every pixel reads 3'b000 in the first frame after the sweep.
